// File: rtl/rib_arbiter.sv
// rib_arbiter: N-master to one-slave RIB bus arbiter with response timeout.
// Define RIB_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority.
module rib_arbiter #(
  parameter int NUM_M   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_M-1:0]  m_req_i,
  input  logic [NUM_M-1:0]  m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_wdata_i,
  output logic [DW-1:0]     m_rdata_o,
  output logic [NUM_M-1:0]  m_ack_o,
  output logic              m_err_o,
  output logic [NUM_M-1:0]  m_hold_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW-1:0]     s_wdata_o,
  input  logic [DW-1:0]     s_rdata_i,
  input  logic              s_ack_i,
  output logic [NUM_M-1:0]  grant_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_MAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t           state, state_n;
  logic [NUM_M-1:0] grant, grant_n;
  logic [NUM_M-1:0] win;
  logic [CW-1:0]    cnt, cnt_n;
  logic [DW-1:0]    rdata_q, rdata_n;
  logic             err_q, err_n;
  logic             to_hit;

`ifdef RIB_ARB_ROUND_ROBIN_EN
  localparam int IW = $clog2(NUM_M);
  logic [IW-1:0] ptr;
  logic [IW-1:0] win_idx;
  logic          found;
  int            j;

  // Round-robin pick: first requester after the last winner.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      j = (int'(ptr) + k) % NUM_M;
      if (!found && m_req_i[j]) begin
        win[j]  = 1'b1;
        win_idx = IW'(j);
        found   = 1'b1;
      end
    end
  end

  // Pointer follows each new grant; master 0 goes first after reset.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= IW'(NUM_M - 1);
    else if (state == IDLE && |m_req_i)
      ptr <= win_idx;
  end
`else
  // Fixed priority pick: lowest requesting index wins.
  always_comb begin
    win = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (m_req_i[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`endif

  assign to_hit = TO_EN && (cnt == CNT_MAX);

  // State, grant, timeout counter and captured response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      cnt     <= cnt_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  // Next-state: ack beats timeout when both land together.
  always_comb begin
    state_n = state;
    grant_n = grant;
    cnt_n   = cnt;
    rdata_n = rdata_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (|m_req_i) begin
          grant_n = win;
          state_n = BUSY;
        end
      end
      BUSY: begin
        cnt_n = cnt + 1'b1;
        if (s_ack_i) begin
          rdata_n = s_rdata_i;
          err_n   = 1'b0;
          cnt_n   = '0;
          state_n = RESP;
        end else if (to_hit) begin
          rdata_n = '0;
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = RESP;
        end
      end
      RESP: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Slave side driven from the owner's live inputs, only in BUSY.
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (state == BUSY) begin
      s_req_o = 1'b1;
      for (int i = 0; i < NUM_M; i++) begin
        if (grant[i]) begin
          s_we_o    = m_we_i[i];
          s_addr_o  = m_addr_i[i*AW +: AW];
          s_wdata_o = m_wdata_i[i*DW +: DW];
        end
      end
    end
  end

  assign m_ack_o   = (state == RESP) ? grant : '0;
  assign m_err_o   = (state == RESP) && err_q;
  assign m_rdata_o = (state == RESP) ? rdata_q : '0;
  assign m_hold_o  = m_req_i & ~m_ack_o;
  assign grant_o   = grant;

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed checks for rib_arbiter (NUM_M=4, TIMEOUT=4).
// Expectations follow RIB_ARB_ROUND_ROBIN_EN when it is defined.
module tb_rib_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

`ifdef RIB_ARB_ROUND_ROBIN_EN
  localparam logic [NM-1:0] G2ND = 4'b0010;
`else
  localparam logic [NM-1:0] G2ND = 4'b0001;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_ack;
  logic             m_err;
  logic [NM-1:0]    m_hold;
  logic             s_req;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [DW-1:0]    s_rdata;
  logic             s_ack;
  logic [NM-1:0]    grant;

  int n_run  = 0;
  int n_fail = 0;

  rib_arbiter #(
    .NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req_i   (m_req),
    .m_we_i    (m_we),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_rdata_o (m_rdata),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_hold_o  (m_hold),
    .s_req_o   (s_req),
    .s_we_o    (s_we),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_rdata_i (s_rdata),
    .s_ack_i   (s_ack),
    .grant_o   (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_rdata = '0;
    s_ack   = 1'b0;
    m_addr[0*AW +: AW] = 32'h0000_0100;
    m_addr[1*AW +: AW] = 32'h0000_0200;
    m_addr[2*AW +: AW] = 32'h1000_0040;
    m_addr[3*AW +: AW] = 32'h0000_0300;
    m_wdata[2*DW +: DW] = 32'hA5A5_5A5A;
    tick();
    tick();
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_ack", 64'(m_ack), 64'h0);
    check("rst_sreq", 64'(s_req), 64'h0);
    check("rst_err", 64'(m_err), 64'h0);
    check("rst_rdata", 64'(m_rdata), 64'h0);
    rst = 1'b0;
    tick();

    // single write, master 2, zero-wait slave
    m_req = 4'b0100;
    m_we  = 4'b0100;
    tick();
    check("wr_sreq", 64'(s_req), 64'h1);
    check("wr_swe", 64'(s_we), 64'h1);
    check("wr_saddr", 64'(s_addr), 64'h1000_0040);
    check("wr_swdata", 64'(s_wdata), 64'hA5A5_5A5A);
    check("wr_grant", 64'(grant), 64'h4);
    check("wr_hold", 64'(m_hold), 64'h4);
    check("wr_ack_early", 64'(m_ack), 64'h0);
    s_ack = 1'b1;
    tick();
    check("wr_ack", 64'(m_ack), 64'h4);
    check("wr_err", 64'(m_err), 64'h0);
    check("wr_hold_ack", 64'(m_hold), 64'h0);
    check("wr_sreq_resp", 64'(s_req), 64'h0);
    m_req = '0;
    m_we  = '0;
    s_ack = 1'b0;
    tick();
    check("wr_idle_grant", 64'(grant), 64'h0);
    check("wr_idle_ack", 64'(m_ack), 64'h0);

    // masters 0 and 1 both read continuously
    m_req = 4'b0011;
    tick();
    check("rd1_grant", 64'(grant), 64'h1);
    check("rd1_hold", 64'(m_hold), 64'h3);
    check("rd1_saddr", 64'(s_addr), 64'h100);
    check("rd1_swe", 64'(s_we), 64'h0);
    s_ack   = 1'b1;
    s_rdata = 32'h1234;
    tick();
    check("rd1_ack", 64'(m_ack), 64'h1);
    check("rd1_rdata", 64'(m_rdata), 64'h1234);
    check("rd1_hold1", 64'(m_hold), 64'h2);
    s_ack = 1'b0;
    tick();
    check("rd_idle_grant", 64'(grant), 64'h0);
    tick();
    check("rd2_grant", 64'(grant), 64'(G2ND));
    s_ack   = 1'b1;
    s_rdata = 32'h5678;
    tick();
    check("rd2_ack", 64'(m_ack), 64'(G2ND));
    check("rd2_rdata", 64'(m_rdata), 64'h5678);
    check("rd2_hold", 64'(m_hold), 64'(4'b0011 & ~G2ND));
    m_req = '0;
    s_ack = 1'b0;
    tick();

    // slave never acks: error response after TIMEOUT cycles
    m_req   = 4'b0010;
    s_rdata = 32'hDEAD;
    tick();
    check("to_grant", 64'(grant), 64'h2);
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      check("to_wait_sreq", 64'(s_req), 64'h1);
      check("to_wait_ack", 64'(m_ack), 64'h0);
    end
    tick();
    check("to_ack", 64'(m_ack), 64'h2);
    check("to_err", 64'(m_err), 64'h1);
    check("to_rdata", 64'(m_rdata), 64'h0);
    m_req = '0;
    tick();
    check("to_idle_sreq", 64'(s_req), 64'h0);
    check("to_idle_grant", 64'(grant), 64'h0);
    check("to_idle_err", 64'(m_err), 64'h0);

    // ack lands on the same cycle as the timeout
    m_req = 4'b1000;
    tick();
    tick();
    tick();
    tick();
    check("race_sreq", 64'(s_req), 64'h1);
    s_ack   = 1'b1;
    s_rdata = 32'hCAFE;
    tick();
    check("race_ack", 64'(m_ack), 64'h8);
    check("race_err", 64'(m_err), 64'h0);
    check("race_rdata", 64'(m_rdata), 64'hCAFE);
    m_req = '0;
    s_ack = 1'b0;
    tick();

    // reset while BUSY drops the transaction
    m_req = 4'b0010;
    tick();
    check("rb_grant", 64'(grant), 64'h2);
    rst   = 1'b1;
    m_req = '0;
    tick();
    check("rb_grant0", 64'(grant), 64'h0);
    check("rb_sreq0", 64'(s_req), 64'h0);
    check("rb_ack0", 64'(m_ack), 64'h0);
    check("rb_err0", 64'(m_err), 64'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rb_no_ack", 64'(m_ack), 64'h0);
    end

    // priority restarts at master 0, then master 3 is served
    m_req = 4'b1001;
    m_we  = 4'b1000;
    tick();
    check("rb_first", 64'(grant), 64'h1);
    check("rb_hold", 64'(m_hold), 64'h9);
    s_ack   = 1'b1;
    s_rdata = 32'h1111;
    tick();
    check("rb_ack_m0", 64'(m_ack), 64'h1);
    m_req = 4'b1000;
    s_ack = 1'b0;
    tick();
    tick();
    check("m3_grant", 64'(grant), 64'h8);
    check("m3_saddr", 64'(s_addr), 64'h300);
    check("m3_swe", 64'(s_we), 64'h1);
    s_ack   = 1'b1;
    s_rdata = 32'h3333;
    tick();
    check("m3_ack", 64'(m_ack), 64'h8);
    check("m3_rdata", 64'(m_rdata), 64'h3333);
    m_req = '0;
    m_we  = '0;
    s_ack = 1'b0;
    tick();
    check("m3_idle", 64'(grant), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
